// File: rtl/iterative_subtractor.sv
// Multi-cycle unsigned subtractor y = a - b, K bits per cycle over S = N/K cycles.
// Latency: S cycles from accept to out_valid. Backpressure: DONE is held while out_ready is low; in_ready only in IDLE.
module iterative_subtractor #(
    parameter int N = 64,
    parameter int K = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] y,
    output logic         borrow,
    output logic         zero
);

    localparam int S  = N / K;
    localparam int CW = (S > 1) ? $clog2(S) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  y_q, y_d;
    logic [CW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic          borrow_q, borrow_d;
    logic          zero_q, zero_d;

    logic [K-1:0]  a_sl, b_sl;
    logic [K:0]    sum0, sum1, sum_sel;
    int            base;

    // Both borrow-in outcomes are formed in parallel; the registered carry only drives the mux.
    always_comb begin
        base    = int'(idx_q) * K;
        a_sl    = a_q[base +: K];
        b_sl    = b_q[base +: K];
        sum0    = {1'b0, a_sl} + {1'b0, ~b_sl};
        sum1    = {1'b0, a_sl} + {1'b0, ~b_sl} + {{K{1'b0}}, 1'b1};
        sum_sel = carry_q ? sum1 : sum0;
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        y_d      = y_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        borrow_d = borrow_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                y_d[base +: K] = sum_sel[K-1:0];
                carry_d        = sum_sel[K];
                idx_d          = idx_q + CW'(1);
                if (idx_q == CW'(S - 1)) begin
                    idx_d    = '0;
                    borrow_d = ~sum_sel[K];
                    zero_d   = (y_d == '0);
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            y_q      <= y_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign y         = y_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule

// File: doc/iterative_subtractor.md
# iterative_subtractor

Multi-cycle unsigned subtractor computing y = a - b over N bits, K bits per clock. Each slice evaluates both borrow-in outcomes and selects by the registered carry, so the per-cycle critical path is one K-bit add plus a mux. It is the subtracting counterpart to the team's conditional-sum adders, for datapaths where area matters more than single-cycle latency. Operands enter and results leave on valid/ready handshakes.

## Interface

- N, default 64: operand and result width; must be a multiple of K.
- K, default 8: slice width processed per cycle; 1 <= K <= N.
- S, derived: N/K, the number of slice cycles; counter width clog2(S), minimum 1.

- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a, b valid.
- in_ready  output  1  block can accept operands.
- a  input  N  minuend, unsigned.
- b  input  N  subtrahend, unsigned.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- y  output  N  a - b mod 2^N.
- borrow  output  1  1 iff a < b (unsigned).
- zero  output  1  1 iff y == 0.

## Operation

- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1, out_valid=0. On in_valid && in_ready, latch a and b, clear slice index to 0, set carry register to 1 (two's-complement +1), go to BUSY.
- BUSY: in_ready=0, out_valid=0. Slice i covers bits [i*K+K-1 : i*K]. Compute c0 = a_i + ~b_i + 0 and c1 = a_i + ~b_i + 1, each K+1 bits. Select c1 if carry=1, else c0. Write the low K bits into y slice i. Load bit K into carry. Increment i. After slice S-1, go to DONE.
- DONE: out_valid=1, in_ready=0. y, borrow and zero are held stable.
  - borrow = ~carry after the final slice.
  - zero = (y == 0), registered on entry to DONE.
  - On out_valid && out_ready, go to IDLE.
- in_valid is ignored while in_ready=0. a and b need only be stable in the acceptance cycle.
- y, borrow and zero are don't-care outside DONE; the bench checks them only while out_valid=1.
- The a/b input registers and y are updated only as described above, so no partial value leaks during DONE.
- S=1 (N==K): a single BUSY cycle, then DONE.

## Timing

- Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, y=0, borrow=0, zero=0, slice index=0, carry=1. In-flight operation is discarded.
- Acceptance at rising edge T. Slices 0..S-1 complete at edges T+1..T+S. out_valid=1 from just after edge T+S.
- Latency: S cycles from accept to out_valid (8 for defaults).
- Output handshake at edge U sets out_valid=0 and in_ready=1 after U. Next acceptance is possible no earlier than edge U+1.
- Minimum initiation interval: S+2 cycles.
- out_ready held high before DONE: the result is consumed at the first edge with out_valid=1 (out_valid high for exactly one cycle).
- Back-pressure: out_ready low holds DONE indefinitely with all outputs stable.
- rst_n deasserted mid-BUSY or mid-DONE: outputs return to reset values asynchronously. The operation is not resumed.

## Test plan

- Basic: N=64, K=8, a=0x10, b=0x01 -> y=0x0F, borrow=0, zero=0. out_valid rises exactly 8 cycles after acceptance.
- Underflow: a=0, b=1 -> y=0xFFFF_FFFF_FFFF_FFFF, borrow=1, zero=0.
- Equal operands: a=b=0x1234_5678_9ABC_DEF0 -> y=0, zero=1, borrow=0.
- Cross-slice borrow: a=0x0000_0001_0000_0000, b=1 -> y=0x0000_0000_FFFF_FFFF, borrow=0.
- Back-pressure and input blocking:
  - Hold out_ready=0 for 5 cycles in DONE: out_valid stays 1, y/borrow/zero unchanged, in_ready stays 0.
  - in_valid pulses during BUSY/DONE with other operands: ignored; result unchanged.
- Reset mid-operation: assert rst_n=0 in the 3rd BUSY cycle -> out_valid=0, in_ready=1 immediately. After release, a=100, b=58 -> y=42 after 8 cycles.
